// File: rtl/quadrilatero_mesh_sequencer.sv
// Job sequencer for a MESH_WIDTH x MESH_WIDTH systolic mesh: accepts a K-vector job, skews rows, drains, pulses done.
// Optional macro QUADRILATERO_SEQ_STALL_CNT_EN enables the saturating FEED stall counter on stall_cnt_o.
module quadrilatero_mesh_sequencer #(
  parameter int MESH_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_valid_i,
  output logic                             start_ready_o,
  input  logic [K_WIDTH-1:0]               k_i,
  input  logic                             data_valid_i,
  output logic                             data_ready_o,
  input  logic [MESH_WIDTH*DATA_WIDTH-1:0] data_i,
  output logic [MESH_WIDTH*DATA_WIDTH-1:0] mesh_data_o,
  output logic [MESH_WIDTH-1:0]            mesh_valid_o,
  output logic                             pump_o,
  output logic                             done_o,
  output logic [15:0]                      stall_cnt_o
);

  localparam int DRAIN_LAST = 2 * MESH_WIDTH - 2;
  localparam int DCW        = $clog2(2 * MESH_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [K_WIDTH-1:0]              r_remaining;
  logic [DCW-1:0]                  r_drain_cnt;
  logic                            w_accept;
  logic                            w_pump;
  logic                            w_inj_vld;
  logic [MESH_WIDTH*DATA_WIDTH-1:0] w_inj_dat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    start_ready_o = 1'b0;
    data_ready_o  = 1'b0;
    w_pump        = 1'b0;
    done_o        = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (k_i == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        data_ready_o = data_valid_i;
        w_pump       = data_valid_i;
        if (data_valid_i && r_remaining == K_WIDTH'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_pump = 1'b1;
        if (r_drain_cnt == DCW'(DRAIN_LAST)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pump_o    = w_pump;
  assign w_inj_vld = (r_state == S_FEED);
  assign w_inj_dat = w_inj_vld ? data_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_remaining <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept)          r_remaining <= k_i;
      else if (data_ready_o) r_remaining <= r_remaining - K_WIDTH'(1);
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DCW'(1) : '0;
    end
  end

`ifdef QUADRILATERO_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                        r_stall_cnt <= '0;
    else if (w_accept)                                                r_stall_cnt <= '0;
    else if (r_state == S_FEED && !data_valid_i && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  // Row r keeps r+1 pump-qualified stages; its last stage drives the mesh, so row r lags row 0 by r pumps.
  for (genvar r = 0; r < MESH_WIDTH; r++) begin : g_row
    logic [DATA_WIDTH-1:0] r_pipe  [0:r];
    logic                  r_vpipe [0:r];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s <= r; s++) begin
          r_pipe[s]  <= '0;
          r_vpipe[s] <= 1'b0;
        end
      end else if (w_pump) begin
        r_pipe[0]  <= w_inj_dat[r*DATA_WIDTH +: DATA_WIDTH];
        r_vpipe[0] <= w_inj_vld;
        for (int s = 1; s <= r; s++) begin
          r_pipe[s]  <= r_pipe[s-1];
          r_vpipe[s] <= r_vpipe[s-1];
        end
      end
    end

    assign mesh_data_o[r*DATA_WIDTH +: DATA_WIDTH] = r_pipe[r];
    assign mesh_valid_o[r]                          = r_vpipe[r];
  end

endmodule

// File: doc/quadrilatero_mesh_sequencer.md
QUADRILATERO_MESH_SEQUENCER -- requirements
Module: quadrilatero_mesh_sequencer

Interface
REQ-001 SHALL have parameter MESH_WIDTH, default 4, meaning mesh rows/columns.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning element width in bits.
REQ-003 SHALL have parameter K_WIDTH, default 8, meaning width of the job length field.
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
REQ-005 SHALL have the following job ports:
- start_valid_i  input  1  job request
- start_ready_o  output  1  sequencer can accept a job
- k_i  input  K_WIDTH  number of data vectors in the job
REQ-006 SHALL have the following data ports:
- data_valid_i  input  1  input vector valid
- data_ready_o  output  1  input vector consumed this cycle
- data_i  input  MESH_WIDTH*DATA_WIDTH  unskewed vector, row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
REQ-007 SHALL have the following mesh ports:
- mesh_data_o  output  MESH_WIDTH*DATA_WIDTH  skewed row inputs to mesh data_i
- mesh_valid_o  output  MESH_WIDTH  per-row valid qualifier for sa_ctrl
- pump_o  output  1  mesh advance enable
- done_o  output  1  one-cycle job-complete pulse
- stall_cnt_o  output  16  stall counter

Function
REQ-008 SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-009 SHALL drive start_ready_o=1 only in IDLE.
REQ-010 SHALL transition IDLE->FEED on start_valid_i&&start_ready_o with k_i!=0, latching k_i into a remaining counter.
REQ-011 SHALL transition IDLE->DONE on a handshake with k_i==0, without pumping.
REQ-012 SHALL, in FEED, assert data_ready_o=data_valid_i and pump_o=data_valid_i.
REQ-013 SHALL decrement the remaining counter on each consumed vector.
REQ-014 SHALL transition FEED->DRAIN on the cycle the last vector is consumed.
REQ-015 SHALL treat a FEED cycle with data_valid_i=0 as a stall: pump_o=0, skew registers hold, mesh_valid_o holds.
REQ-016 SHALL apply skew as follows: row r passes through r register stages, so row 0 is combinational from the stage-0 register and row r lags row 0 by r pump cycles.
REQ-017 SHALL advance the skew registers only when pump_o=1.
REQ-018 SHALL, in DRAIN, assert pump_o=1 every cycle, inject zero data with valid=0 into stage 0, and keep data_ready_o=0.
REQ-019 SHALL remain in DRAIN for exactly 2*MESH_WIDTH-1 cycles, counted by a drain counter, then transition to DONE.
REQ-020 SHALL assert done_o=1 for exactly one cycle in DONE, with pump_o=0, then transition DONE->IDLE.
REQ-021 SHALL ignore start_valid_i outside IDLE; no queuing.
REQ-022 SHALL, for job length K, produce exactly K+2*MESH_WIDTH-1 pump cycles from the accept cycle to done_o, excluding stalls.
REQ-023 SHALL ensure mesh_valid_o[r]=1 exactly when mesh_data_o row r carries a real input element.
REQ-024 SHALL have data_ready_o and pump_o be functions of the current state and data_valid_i only, with no combinational path from start_valid_i.

Reset
REQ-025 SHALL, while rst_i=1, asynchronously set the state to IDLE and clear all counters and skew registers.
REQ-026 SHALL hold the following output values in reset: start_ready_o=1, data_ready_o=0, pump_o=0, done_o=0, mesh_data_o=0, mesh_valid_o=0, stall_cnt_o=0.
REQ-027 SHALL abandon a job in progress when reset is asserted mid-job, without asserting done_o.

Configuration
REQ-028 SHALL, when macro QUADRILATERO_SEQ_STALL_CNT_EN is defined, implement stall_cnt_o as follows:
- increments on each FEED stall cycle
- saturates at 16'hFFFF
- clears on each job accept
REQ-029 SHALL, without QUADRILATERO_SEQ_STALL_CNT_EN, tie stall_cnt_o to 0 and contain no counter logic.

Verification
REQ-030 SHALL cover: MESH_WIDTH=4, k_i=3, data_valid_i held 1 -> pump_o high for 10 consecutive cycles, done_o one cycle later, start_ready_o=1 the cycle after done_o.
REQ-031 SHALL cover: vectors {1,2,3,4} then {5,6,7,8}, rows r -> row 3 output shows 4 three pump cycles after row 0 shows 1; mesh_valid_o walks 0001,0011,0111,1111.
REQ-032 SHALL cover: k_i=4 with data_valid_i deasserted for 5 cycles mid-FEED -> pump_o=0 and outputs frozen for those 5 cycles, stall_cnt_o=5 (macro on) or 0 (macro off).
REQ-033 SHALL cover: k_i=0 handshake -> done_o on the next cycle, no pump_o assertion.
REQ-034 SHALL cover: rst_i asserted during DRAIN -> all outputs at reset values immediately, no done_o, next job runs normally.
REQ-035 SHALL cover: start_valid_i held high throughout a job -> exactly one accept, with a second accept only after the DONE->IDLE transition.
